chan_incr_pipe: RTL and testbench
=================================

Name: chan_incr_pipe

Overview:
- Parametrised, multi-channel, handshaked successor to the fixed-width output incrementers in the Verilator example top.
- Each accepted beat carries CHANNELS lanes of WIDTH bits. Every lane has STEP added, with either wrap or saturate arithmetic.
- Results pass through a 2-entry skid buffer, which gives full throughput with a registered in_ready.
- Sits between testbench stimulus and the Rust harness. It also exposes sticky per-lane overflow flags and a transfer counter for harness checking.

Parameters:
- WIDTH, 70: bits per lane, minimum 1.
- CHANNELS, 3: number of lanes, minimum 1.
- STEP, 1: unsigned addend applied to every lane, truncated to WIDTH bits.
- SATURATE, 0: 0 = modular wrap; 1 = clamp result to all-ones.

Ports:
- clk, input, 1: rising-edge clock.
- reset_l, input, 1: asynchronous active-low reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: input beat accepted when in_valid and in_ready are both 1.
- in_data, input, CHANNELS*WIDTH: lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: output beat consumed when out_valid and out_ready are both 1.
- out_data, output, CHANNELS*WIDTH: incremented lanes, same packing as in_data.
- ovf_sticky, output, CHANNELS: per-lane flag, set when the lane's true sum exceeded 2^WIDTH-1.
- ovf_clr, input, 1: synchronous clear of all ovf_sticky bits.
- xfer_count, output, 32: count of output handshakes.

Behaviour:
- Reset (reset_l=0, asynchronous): in_ready=1, out_valid=0, out_data=0, ovf_sticky=0, xfer_count=0, buffer occupancy=0.
  - Deassertion takes effect on the next clk edge.
  - Reset mid-transfer discards all buffered beats without producing output.
- Arithmetic, per lane: sum = {1'b0,in_lane} + STEP, computed at WIDTH+1 bits.
  - ovf = sum[WIDTH].
  - SATURATE=0: result = sum[WIDTH-1:0].
  - SATURATE=1: result = ovf ? all-ones : sum[WIDTH-1:0].
  - Computed on the accepted beat; no combinational path from in_data to out_data.
- Buffer: 2 entries, FIFO order, tracked by occupancy count 0..2.
  - in_ready = (occupancy < 2), registered.
  - out_valid = (occupancy != 0), registered.
  - out_data is driven from the head entry.
- Latency: a beat accepted on edge N appears on out_data/out_valid after edge N.
  - Minimum latency is 1 cycle when the buffer is empty.
  - Sustained throughput is 1 beat per cycle while out_ready=1.
- Occupancy update per edge: +1 on accept only, -1 on consume only, unchanged on both or neither.
  - Simultaneous accept and consume at occupancy 1 forwards the new beat to head with no bubble.
  - At occupancy 2 no accept is possible, since in_ready=0.
- Handshake rules:
  - out_data and out_valid are held stable while out_valid=1 and out_ready=0.
  - in_valid without in_ready has no effect.
  - in_data is ignored whenever in_valid=0.
- ovf_sticky[k] sets on the accept edge if lane k overflowed. This applies in both modes.
  - ovf_clr=1 clears all bits.
  - If ovf_clr and a new overflow occur on the same edge, set wins.
- xfer_count increments on each output handshake and wraps from 2^32-1 to 0.

Optional Feature:
- Macro: CHAN_INCR_PIPE_PARITY_EN.
- Defined: adds output port out_parity [CHANNELS-1:0].
  - Bit k is the XOR of out_data lane k.
  - It is stored in the buffer alongside the lane, so it obeys the same valid/stable rules.
  - Reset value is 0.
- Undefined: the port and its storage are absent. All other behaviour is identical.

Decomposition:
- Package chan_incr_pkg:
  - localparam OCC_W = 2.
  - Typedef occ_t for the buffer occupancy.
  - Function for lane slice index arithmetic.
  - XFER_W = 32.
- Sub-module chan_incr_lane: combinational, one per lane via generate.
  - Parameters WIDTH, STEP, SATURATE.
  - Ports lane_in, lane_out, lane_ovf.
- chan_incr_pipe owns the buffer, the counters and the sticky flags.

Test Plan:
- Reset values: hold reset_l=0 with in_valid=1 -> in_ready=1, out_valid=0, out_data=0, xfer_count=0. Assert reset_l=0 mid-stream with 2 beats buffered -> out_valid drops immediately.
- Wrap mode (WIDTH=2, CHANNELS=3, STEP=1, SATURATE=0): lanes {3,1,0} -> out lanes {0,2,1} after 1 cycle; ovf_sticky=3'b100.
- Saturate mode (WIDTH=2, STEP=1, SATURATE=1): lanes {3,2,3} -> out lanes {3,3,3}; ovf_sticky=3'b101. Then ovf_clr=1 with no overflow -> ovf_sticky=0.
- Backpressure: out_ready=0 and 3 beats offered -> in_ready=0 after 2 accepts, out_data stable. Release out_ready -> beats emerge in order; xfer_count=3.
- Throughput: WIDTH=70, 100 back-to-back beats with out_ready=1 -> 100 outputs in 101 cycles. Input 2^70-1 -> output 0 with ovf set (wrap mode).
- Parity (with CHAN_INCR_PIPE_PARITY_EN): WIDTH=2, in lane 2'b01, STEP=1 -> out lane 2'b10 with out_parity bit 1. In lane 2'b10 -> out lane 2'b11 with out_parity bit 0.

Source files
------------

// File: rtl/chan_incr_pkg.sv
// chan_incr_pkg: shared widths, occupancy type and lane slicing helper for chan_incr_pipe.
package chan_incr_pkg;
    localparam int OCC_W = 2;
    localparam int XFER_W = 32;
    typedef logic [OCC_W-1:0] occ_t;
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/chan_incr_lane.sv
// chan_incr_lane: one lane of the incrementer, wrap or saturate, with carry-out overflow.
module chan_incr_lane #(
    parameter int unsigned WIDTH    = 70,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic [WIDTH-1:0] lane_in,
    output logic [WIDTH-1:0] lane_out,
    output logic             lane_ovf
);
    localparam logic [WIDTH:0] STEP_X = {1'b0, WIDTH'(STEP)};
    logic [WIDTH:0] sum;
    always_comb begin
        sum      = {1'b0, lane_in} + STEP_X;
        lane_ovf = sum[WIDTH];
        lane_out = (SATURATE != 0 && lane_ovf) ? '1 : sum[WIDTH-1:0];
    end
endmodule

// File: rtl/chan_incr_pipe.sv
// chan_incr_pipe: multi-lane incrementer behind a 2-entry skid buffer, with sticky overflow and transfer count.
// Optional macro CHAN_INCR_PIPE_PARITY_EN adds per-lane parity stored alongside the data.
module chan_incr_pipe
    import chan_incr_pkg::*;
#(
    parameter int unsigned WIDTH    = 70,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        reset_l,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHANNELS*WIDTH-1:0]   out_data,
    output logic [CHANNELS-1:0]         ovf_sticky,
    input  logic                        ovf_clr,
    output logic [XFER_W-1:0]           xfer_count
`ifdef CHAN_INCR_PIPE_PARITY_EN
    ,
    output logic [CHANNELS-1:0]         out_parity
`endif
);
    localparam int DW = CHANNELS * WIDTH;
`ifdef CHAN_INCR_PIPE_PARITY_EN
    localparam int EW = DW + CHANNELS;
`else
    localparam int EW = DW;
`endif

    logic [DW-1:0]       inc_data;
    logic [CHANNELS-1:0] inc_ovf;
    logic [CHANNELS-1:0] inc_par;
    logic [EW-1:0]       inc_ent;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        chan_incr_lane #(.WIDTH(WIDTH), .STEP(STEP), .SATURATE(SATURATE)) u_lane (
            .lane_in (in_data[lane_lo(k, WIDTH) +: WIDTH]),
            .lane_out(inc_data[lane_lo(k, WIDTH) +: WIDTH]),
            .lane_ovf(inc_ovf[k])
        );
        assign inc_par[k] = ^inc_data[lane_lo(k, WIDTH) +: WIDTH];
    end

`ifdef CHAN_INCR_PIPE_PARITY_EN
    assign inc_ent = {inc_par, inc_data};
`else
    assign inc_ent = inc_data;
    logic unused_par;
    assign unused_par = ^inc_par;
`endif

    occ_t              occ_q, occ_d;
    logic [EW-1:0]     ent0_q, ent0_d, ent1_q, ent1_d;
    logic              rdy_q, rdy_d, vld_q, vld_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [XFER_W-1:0] xfer_q, xfer_d;
    logic              acc, pop;

    always_comb begin
        acc    = in_valid && rdy_q;
        pop    = vld_q && out_ready;
        occ_d  = occ_q + occ_t'(acc) - occ_t'(pop);
        // Head refills from the tail slot when full, else straight from the new beat.
        ent0_d = ent0_q;
        if (pop && occ_q == 2'd2)
            ent0_d = ent1_q;
        else if (acc && (pop || occ_q == 2'd0))
            ent0_d = inc_ent;
        ent1_d = (acc && !pop && occ_q == 2'd1) ? inc_ent : ent1_q;
        rdy_d  = occ_d != 2'd2;
        vld_d  = occ_d != 2'd0;
        ovf_d  = (ovf_clr ? '0 : ovf_q) | (acc ? inc_ovf : '0);
        xfer_d = xfer_q + XFER_W'(pop);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            occ_q  <= '0;
            ent0_q <= '0;
            ent1_q <= '0;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            ovf_q  <= '0;
            xfer_q <= '0;
        end else begin
            occ_q  <= occ_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            rdy_q  <= rdy_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
            xfer_q <= xfer_d;
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = vld_q;
    assign out_data   = ent0_q[DW-1:0];
    assign ovf_sticky = ovf_q;
    assign xfer_count = xfer_q;
`ifdef CHAN_INCR_PIPE_PARITY_EN
    assign out_parity = ent0_q[EW-1:DW];
`endif
endmodule

// File: tb/tb_chan_incr_pipe.sv
// tb_chan_incr_pipe: directed checks on wrap (W=2), saturate (W=2) and wide (W=70) instances.
module tb_chan_incr_pipe;
    logic clk = 1'b0;
    logic reset_l;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic        a_iv, a_ir, a_ov, a_or, a_clr;
    logic [5:0]  a_id, a_od;
    logic [2:0]  a_ovf, a_par;
    logic [31:0] a_xc;
    logic        s_iv, s_ir, s_ov, s_or, s_clr;
    logic [5:0]  s_id, s_od;
    logic [2:0]  s_ovf, s_par;
    logic [31:0] s_xc;
    logic         b_iv, b_ir, b_ov, b_or, b_clr;
    logic [209:0] b_id, b_od;
    logic [2:0]   b_ovf, b_par;
    logic [31:0]  b_xc;

    chan_incr_pipe #(.WIDTH(2), .CHANNELS(3), .STEP(1), .SATURATE(0)) u_a (
        .clk(clk), .reset_l(reset_l), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .ovf_sticky(a_ovf),
        .ovf_clr(a_clr), .xfer_count(a_xc)
`ifdef CHAN_INCR_PIPE_PARITY_EN
        , .out_parity(a_par)
`endif
    );
    chan_incr_pipe #(.WIDTH(2), .CHANNELS(3), .STEP(1), .SATURATE(1)) u_s (
        .clk(clk), .reset_l(reset_l), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_id),
        .out_valid(s_ov), .out_ready(s_or), .out_data(s_od), .ovf_sticky(s_ovf),
        .ovf_clr(s_clr), .xfer_count(s_xc)
`ifdef CHAN_INCR_PIPE_PARITY_EN
        , .out_parity(s_par)
`endif
    );
    chan_incr_pipe #(.WIDTH(70), .CHANNELS(3), .STEP(1), .SATURATE(0)) u_b (
        .clk(clk), .reset_l(reset_l), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .ovf_sticky(b_ovf),
        .ovf_clr(b_clr), .xfer_count(b_xc)
`ifdef CHAN_INCR_PIPE_PARITY_EN
        , .out_parity(b_par)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [209:0] beat(input int i);
        logic [209:0] r;
        for (int k = 0; k < 3; k++) r[k*70 +: 70] = 70'(i * 3 + k);
        if (i == 0) r[69:0] = '1;
        return r;
    endfunction

    function automatic logic [209:0] incd(input logic [209:0] v);
        logic [209:0] r;
        for (int k = 0; k < 3; k++) r[k*70 +: 70] = v[k*70 +: 70] + 70'd1;
        return r;
    endfunction

    task automatic test_reset();
        reset_l = 1'b0;
        a_iv = 1'b1; a_id = 6'b111111; b_iv = 1'b1; b_id = '1;
        step();
        step();
        total++; if (a_ir !== 1'b1) $display("FAIL reset_in_ready got %b want 1", a_ir); else passed++;
        total++; if (a_ov !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a_ov); else passed++;
        total++; if (a_od !== 6'd0) $display("FAIL reset_out_data got %h want 0", a_od); else passed++;
        total++; if (a_xc !== 32'd0) $display("FAIL reset_xfer got %0d want 0", a_xc); else passed++;
        total++; if (a_ovf !== 3'b000) $display("FAIL reset_ovf got %b want 000", a_ovf); else passed++;
        total++; if (b_ov !== 1'b0) $display("FAIL reset_wide_valid got %b want 0", b_ov); else passed++;
        a_iv = 1'b0; b_iv = 1'b0;
        reset_l = 1'b1;
        step();
        total++; if (a_ov !== 1'b0) $display("FAIL reset_release_valid got %b want 0", a_ov); else passed++;
    endtask

    task automatic test_wrap();
        a_or = 1'b1; a_iv = 1'b1; a_id = {2'd3, 2'd1, 2'd0};
        step();
        a_iv = 1'b0;
        total++; if (a_ov !== 1'b1) $display("FAIL wrap_valid got %b want 1", a_ov); else passed++;
        total++; if (a_od !== {2'd0, 2'd2, 2'd1}) $display("FAIL wrap_data got %b want 001001", a_od); else passed++;
        total++; if (a_ovf !== 3'b100) $display("FAIL wrap_ovf got %b want 100", a_ovf); else passed++;
        step();
        total++; if (a_ov !== 1'b0) $display("FAIL wrap_drain got %b want 0", a_ov); else passed++;
        total++; if (a_xc !== 32'd1) $display("FAIL wrap_xfer got %0d want 1", a_xc); else passed++;
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        total++; if (a_ovf !== 3'b000) $display("FAIL wrap_clr got %b want 000", a_ovf); else passed++;
    endtask

    task automatic test_saturate();
        s_or = 1'b1; s_iv = 1'b1; s_id = {2'd3, 2'd2, 2'd3};
        step();
        total++; if (s_od !== 6'b111111) $display("FAIL sat_data got %b want 111111", s_od); else passed++;
        total++; if (s_ovf !== 3'b101) $display("FAIL sat_ovf got %b want 101", s_ovf); else passed++;
        s_clr = 1'b1; s_id = {2'd0, 2'd0, 2'd0};
        step();
        total++; if (s_ovf !== 3'b000) $display("FAIL sat_clr got %b want 000", s_ovf); else passed++;
        total++; if (s_od !== {2'd1, 2'd1, 2'd1}) $display("FAIL sat_small got %b want 010101", s_od); else passed++;
        s_id = {2'd3, 2'd0, 2'd0};
        step();
        s_clr = 1'b0; s_iv = 1'b0;
        total++; if (s_ovf !== 3'b100) $display("FAIL sat_set_wins got %b want 100", s_ovf); else passed++;
        total++; if (s_od !== {2'd3, 2'd1, 2'd1}) $display("FAIL sat_clamp got %b want 110101", s_od); else passed++;
        step();
    endtask

    task automatic test_reset_midstream();
        a_or = 1'b0; a_iv = 1'b1; a_id = 6'b000000;
        step();
        step();
        a_iv = 1'b0;
        total++; if (a_ir !== 1'b0) $display("FAIL mid_full_ready got %b want 0", a_ir); else passed++;
        #2 reset_l = 1'b0;
        #1;
        total++; if (a_ov !== 1'b0) $display("FAIL mid_reset_valid got %b want 0", a_ov); else passed++;
        total++; if (a_ir !== 1'b1) $display("FAIL mid_reset_ready got %b want 1", a_ir); else passed++;
        total++; if (a_xc !== 32'd0) $display("FAIL mid_reset_xfer got %0d want 0", a_xc); else passed++;
        step();
        reset_l = 1'b1;
        a_or = 1'b1;
        step();
        total++; if (a_ov !== 1'b0) $display("FAIL mid_discard got %b want 0", a_ov); else passed++;
    endtask

    task automatic test_backpressure();
        a_or = 1'b0; a_iv = 1'b1; a_id = {2'd1, 2'd2, 2'd0};
        step();
        total++; if (a_ir !== 1'b1) $display("FAIL bp_ready1 got %b want 1", a_ir); else passed++;
        a_id = {2'd0, 2'd0, 2'd0};
        step();
        total++; if (a_ir !== 1'b0) $display("FAIL bp_ready2 got %b want 0", a_ir); else passed++;
        total++; if (a_od !== {2'd2, 2'd3, 2'd1}) $display("FAIL bp_head got %b want 101101", a_od); else passed++;
        a_id = {2'd2, 2'd1, 2'd3};
        step();
        total++; if (a_ov !== 1'b1 || a_od !== {2'd2, 2'd3, 2'd1}) $display("FAIL bp_stable got %b/%b want 1/101101", a_ov, a_od); else passed++;
        total++; if (a_ir !== 1'b0) $display("FAIL bp_still_full got %b want 0", a_ir); else passed++;
        a_or = 1'b1;
        step();
        total++; if (a_od !== {2'd1, 2'd1, 2'd1}) $display("FAIL bp_order2 got %b want 010101", a_od); else passed++;
        total++; if (a_ir !== 1'b1) $display("FAIL bp_ready_back got %b want 1", a_ir); else passed++;
        step();
        a_iv = 1'b0;
        total++; if (a_od !== {2'd3, 2'd2, 2'd0}) $display("FAIL bp_order3 got %b want 111000", a_od); else passed++;
        step();
        total++; if (a_ov !== 1'b0) $display("FAIL bp_empty got %b want 0", a_ov); else passed++;
        total++; if (a_xc !== 32'd3) $display("FAIL bp_xfer got %0d want 3", a_xc); else passed++;
    endtask

    task automatic test_throughput();
        int sent = 0;
        int rcv = 0;
        logic ir_pre;
        b_or = 1'b1; b_iv = 1'b1; b_id = beat(0);
        for (int c = 0; c < 101; c++) begin
            ir_pre = b_ir;
            step();
            if (b_iv && ir_pre) sent++;
            if (b_ov) begin
                total++;
                if (b_od !== incd(beat(rcv))) $display("FAIL tp_data%0d got %h want %h", rcv, b_od, incd(beat(rcv)));
                else passed++;
                rcv++;
            end
            b_iv = sent < 100;
            b_id = beat(sent);
        end
        b_iv = 1'b0;
        total++; if (rcv !== 100) $display("FAIL tp_count got %0d want 100", rcv); else passed++;
        total++; if (b_xc !== 32'd100) $display("FAIL tp_xfer got %0d want 100", b_xc); else passed++;
        total++; if (b_ov !== 1'b0) $display("FAIL tp_drained got %b want 0", b_ov); else passed++;
        total++; if (b_ovf !== 3'b001) $display("FAIL tp_ovf got %b want 001", b_ovf); else passed++;
    endtask

`ifdef CHAN_INCR_PIPE_PARITY_EN
    task automatic test_parity();
        a_or = 1'b1; a_iv = 1'b1; a_id = {2'b00, 2'b10, 2'b01};
        step();
        a_iv = 1'b0;
        total++; if (a_od !== {2'b01, 2'b11, 2'b10}) $display("FAIL par_data got %b want 011110", a_od); else passed++;
        total++; if (a_par !== 3'b101) $display("FAIL par_bits got %b want 101", a_par); else passed++;
        step();
    endtask
`endif

    initial begin
        reset_l = 1'b0;
        a_iv = 0; a_or = 0; a_clr = 0; a_id = '0;
        s_iv = 0; s_or = 0; s_clr = 0; s_id = '0;
        b_iv = 0; b_or = 0; b_clr = 0; b_id = '0;
        test_reset();
        test_wrap();
        test_saturate();
        test_reset_midstream();
        test_backpressure();
        test_throughput();
`ifdef CHAN_INCR_PIPE_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
